// File: rtl/sampfifo_reader.sv
// sampfifo_reader
//   Read-side controller for the sample FIFO RAM. It owns the read pointer and
//   compares it with the writer's pointer. It issues RAM reads and absorbs the
//   one-cycle RAM read latency in a two-entry output buffer. Samples are
//   presented downstream as an avail/ready stream at up to one per clock.
//
// Ports
//   clk           clock
//   rst           synchronous reset, active-high
//   wptr          writer pointer incl. wrap bit (samples written)
//   flush         discard every unread sample
//   raddr         RAM read address (low bits of rptr)
//   ravail        RAM read enable
//   rdata         RAM read data, valid one cycle after ravail
//   sample_data   head sample (zero while nothing is buffered)
//   sample_avail  sample_data valid
//   sample_ready  consumer accepts; a pop happens when avail & ready
//   rptr          read pointer incl. wrap bit, fed back to the writer
//   level         wptr - rptr modulo 2**(ADDR_W+1); samples not yet fetched

module sampfifo_reader #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   wptr,
  input  logic              flush,
  output logic [ADDR_W-1:0] raddr,
  output logic              ravail,
  input  logic [31:0]       rdata,
  output logic [31:0]       sample_data,
  output logic              sample_avail,
  input  logic              sample_ready,
  output logic [ADDR_W:0]   rptr,
  output logic [ADDR_W:0]   level
);

  logic [ADDR_W:0] rptr_q;
  logic            inflight;
  logic [1:0]      occ;
  logic            head;
  logic            tail;
  logic [31:0]     entry0;
  logic [31:0]     entry1;
  logic            pop;
  logic [2:0]      demand;

  assign rptr  = rptr_q;
  assign raddr = rptr_q[ADDR_W-1:0];
  assign level = wptr - rptr_q;

  assign sample_avail = (occ != 2'd0);
  assign pop          = sample_avail & sample_ready;

  // The tail slot is head+occ modulo 2. With a full buffer it lands on the
  // head slot, which only happens when that head is being popped the same
  // cycle, so the freed slot is reused immediately.
  assign tail = head ^ occ[0];

  // Buffer slots the buffer will need after this edge if a new read is also
  // issued; a read is only issued when it is guaranteed a slot on arrival.
  always_comb begin
    demand = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    ravail = !flush && (level != '0) && (demand < 3'd2);
  end

  // Data is masked while the buffer is empty so no stale entry ever shows.
  always_comb begin
    sample_data = 32'd0;
    if (sample_avail) begin
      sample_data = head ? entry1 : entry0;
    end
  end

  // Pointer, latency tracking and output buffer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q   <= '0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      head     <= 1'b0;
      entry0   <= 32'd0;
      entry1   <= 32'd0;
    end else if (flush) begin
      // The read issued last cycle is simply never captured.
      rptr_q   <= wptr;
      inflight <= 1'b0;
      occ      <= 2'd0;
      head     <= 1'b0;
    end else begin
      if (ravail) begin
        rptr_q <= rptr_q + (ADDR_W+1)'(1);
      end
      inflight <= ravail;
      if (inflight) begin
        if (tail) begin
          entry1 <= rdata;
        end else begin
          entry0 <= rdata;
        end
      end
      if (pop) begin
        head <= ~head;
      end
      case ({inflight, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // A capture into a full buffer without a simultaneous pop would lose data;
  // the issue rule is meant to make this impossible.
  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(inflight && (occ == 2'd2) && !pop) && (occ != 2'd3));

endmodule

// File: tb/tb_sampfifo_reader.sv
// tb_sampfifo_reader
//   Self-checking bench for sampfifo_reader with ADDR_W=4. A behavioural RAM
//   with one-cycle read latency sits behind the reader. Every sample written
//   into the RAM model is pushed on an expected queue. The monitor pops and
//   compares it when the reader hands the sample downstream.

module tb_sampfifo_reader;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W:0]   wptr = '0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] raddr;
  logic              ravail;
  logic [31:0]       rdata = 32'd0;
  logic [31:0]       sample_data;
  logic              sample_avail;
  logic              sample_ready = 1'b0;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   level;

  logic [31:0] mem [16];
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [31:0] stall_data;
  logic        stall_prev = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  sampfifo_reader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .wptr         (wptr),
    .flush        (flush),
    .raddr        (raddr),
    .ravail       (ravail),
    .rdata        (rdata),
    .sample_data  (sample_data),
    .sample_avail (sample_avail),
    .sample_ready (sample_ready),
    .rptr         (rptr),
    .level        (level)
  );

  always #5 clk = ~clk;

  // Sample RAM: registered read, data one cycle after the enable.
  always @(posedge clk) begin
    if (ravail) rdata <= mem[raddr];
  end

  // Scoreboard and hold-stability monitor. Inputs only change just after a
  // rising edge, so values seen at the falling edge are what the next rising
  // edge acts on.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        vectors++;
        if (sample_avail !== 1'b1 || sample_data !== stall_data) begin
          miscompares++;
          $display("[TB] FAIL hold_stable: avail=%0b data=%h, required avail=1 data=%h",
                   sample_avail, sample_data, stall_data);
        end
      end
      if (sample_avail && sample_ready && !flush) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_sample: got %h, required no sample", sample_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (sample_data !== mon_exp) begin
            miscompares++;
            $display("[TB] FAIL sample_data: got %h, required %h", sample_data, mon_exp);
          end
        end
      end
      stall_prev = sample_avail && !sample_ready && !flush;
      stall_data = sample_data;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    flush = 1'b0;
    wptr = '0;
    sample_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input int budget, output int left);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    left = exp_q.size();
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if (ravail !== 1'b0 || sample_avail !== 1'b0 || level !== 5'd0 ||
          rptr !== 5'd0 || sample_data !== 32'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_idle: ravail=%0b avail=%0b level=%0d rptr=%0d data=%h, required 0 0 0 0 0",
                 ravail, sample_avail, level, rptr, sample_data);
      end
    end
  endtask

  task automatic test_single();
    int left;
    @(posedge clk); #1;
    mem[0] = 32'hA5A5_0001;
    exp_q.push_back(32'hA5A5_0001);
    wptr = 5'd1;
    sample_ready = 1'b1;
    #1;
    vectors++;
    if (ravail !== 1'b1 || raddr !== 4'd0 || level !== 5'd1) begin
      miscompares++;
      $display("[TB] FAIL single_issue: ravail=%0b raddr=%0d level=%0d, required 1 0 1",
               ravail, raddr, level);
    end
    @(negedge clk);
    vectors++;
    if (sample_avail !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_cycle0: avail=%0b, required 0", sample_avail);
    end
    @(negedge clk);
    vectors++;
    if (sample_avail !== 1'b0 || ravail !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_cycle1: avail=%0b ravail=%0b, required 0 0", sample_avail, ravail);
    end
    @(negedge clk);
    vectors++;
    if (sample_avail !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_cycle2: avail=%0b, required 1", sample_avail);
    end
    @(negedge clk);
    vectors++;
    if (sample_avail !== 1'b0 || level !== 5'd0 || rptr !== 5'd1) begin
      miscompares++;
      $display("[TB] FAIL single_empty: avail=%0b level=%0d rptr=%0d, required 0 0 1",
               sample_avail, level, rptr);
    end
    wait_drain(10, left);
    vectors++;
    if (left !== 0) begin
      miscompares++;
      $display("[TB] FAIL single_drain: %0d left, required 0", left);
    end
  endtask

  task automatic test_burst();
    int left;
    int waited;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      mem[i] = 32'(i);
      exp_q.push_back(32'(i));
    end
    wptr = 5'd8;
    sample_ready = 1'b1;
    waited = 0;
    @(negedge clk);
    while (sample_avail !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (sample_avail !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL burst_gap: beat %0d avail=%0b, required 1", k, sample_avail);
      end
      @(negedge clk);
    end
    vectors++;
    if (sample_avail !== 1'b0 || rptr !== 5'd8) begin
      miscompares++;
      $display("[TB] FAIL burst_end: avail=%0b rptr=%0d, required 0 8", sample_avail, rptr);
    end
    wait_drain(10, left);
    vectors++;
    if (left !== 0) begin
      miscompares++;
      $display("[TB] FAIL burst_drain: %0d left, required 0", left);
    end
  endtask

  task automatic test_backpressure();
    int left;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      mem[i] = 32'h0000_0100 + 32'(i);
      exp_q.push_back(32'h0000_0100 + 32'(i));
    end
    wptr = 5'd8;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      sample_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    sample_ready = 1'b1;
    left = exp_q.size();
    vectors++;
    if (left !== 0 || rptr !== 5'd8) begin
      miscompares++;
      $display("[TB] FAIL backpressure_end: %0d left rptr=%0d, required 0 8", left, rptr);
    end
  endtask

  task automatic test_wrap();
    int left;
    logic [3:0] addr_q[$];
    logic [3:0] want;
    do_reset();
    wptr = 5'd14;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++;
    if (rptr !== 5'd14 || level !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL wrap_start: rptr=%0d level=%0d, required 14 0", rptr, level);
    end
    for (int i = 0; i < 4; i++) begin
      want = 4'(14 + i);
      mem[want] = 32'hC0DE_0000 + 32'(i);
      exp_q.push_back(32'hC0DE_0000 + 32'(i));
      addr_q.push_back(want);
    end
    wptr = 5'd18;
    sample_ready = 1'b1;
    for (int c = 0; c < 20 && addr_q.size() != 0; c++) begin
      @(negedge clk);
      if (ravail === 1'b1) begin
        want = addr_q.pop_front();
        vectors++;
        if (raddr !== want) begin
          miscompares++;
          $display("[TB] FAIL wrap_raddr: got %0d, required %0d", raddr, want);
        end
      end
    end
    vectors++;
    if (addr_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL wrap_issue_timeout: %0d reads missing, required 0", addr_q.size());
    end
    wait_drain(20, left);
    vectors++;
    if (left !== 0 || rptr !== 5'd18 || level !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL wrap_end: left=%0d rptr=%0d level=%0d, required 0 18 0", left, rptr, level);
    end
  endtask

  task automatic test_flush();
    int left;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h0000_0200 + 32'(i);
      exp_q.push_back(32'h0000_0200 + 32'(i));
    end
    wptr = 5'd16;
    sample_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (sample_avail !== 1'b1 || ravail !== 1'b0 || sample_data !== 32'h0000_0200) begin
      miscompares++;
      $display("[TB] FAIL flush_full: avail=%0b ravail=%0b data=%h, required 1 0 00000200",
               sample_avail, ravail, sample_data);
    end
    @(posedge clk); #1;
    flush = 1'b1;
    sample_ready = 1'b1;
    exp_q.delete();
    #1;
    vectors++;
    if (ravail !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_ravail: ravail=%0b, required 0", ravail);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    sample_ready = 1'b0;
    vectors++;
    if (sample_avail !== 1'b0 || rptr !== 5'd16 || level !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL flush_after: avail=%0b rptr=%0d level=%0d, required 0 16 0",
               sample_avail, rptr, level);
    end
    mem[0] = 32'hBEEF_0000;
    exp_q.push_back(32'hBEEF_0000);
    wptr = 5'd17;
    sample_ready = 1'b1;
    wait_drain(10, left);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (left !== 0 || sample_avail !== 1'b0 || rptr !== 5'd17) begin
      miscompares++;
      $display("[TB] FAIL flush_new: left=%0d avail=%0b rptr=%0d, required 0 0 17",
               left, sample_avail, rptr);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_wrap();
    test_flush();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
